multi_lane_capture_mux: RTL and testbench
=========================================

MULTI_LANE_CAPTURE_MUX -- requirements
Module: multi_lane_capture_mux

Interface
REQ-001 Parameter NUM_LANES, default 4, number of capture lanes; legal range 2..16.
REQ-002 Parameter DATA_W, default 8, width of each lane data register; legal range 1..32.
REQ-003 Derived constants SEL_W = max(1, clog2(NUM_LANES)) and IDX_W = max(1, clog2(DATA_W)) SHALL be computed as localparams, not overridable.
REQ-004 t_i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-low.
REQ-006 i_a  in  DATA_W  data word A, broadcast to all lanes.
REQ-007 i_b  in  DATA_W  data word B, broadcast to all lanes.
REQ-008 i_lane_en  in  NUM_LANES  per-lane capture enable, bit l enables lane l.
REQ-009 i_bit_idx  in  IDX_W  bit index for lane indexed-bit write.
REQ-010 i_bit_val  in  1  indexed-bit write operand.
REQ-011 i_mode  in  2  selector mode: 00 rotate, 01 fixed, 10 hold, 11 reserved (behaves as hold).
REQ-012 i_fix_sel  in  SEL_W  lane number loaded into both selectors in fixed mode.
REQ-013 o_a  out  DATA_W  reg_a of lane sel_a.
REQ-014 o_b  out  DATA_W  reg_b of lane sel_b.
REQ-015 o_c  out  DATA_W  merged indexed-bit word, bit k = reg_c[k mod NUM_LANES][k].
REQ-016 o_sel_a / o_sel_b  out  SEL_W each  current selector values.
REQ-017 o_wrap  out  1  one-cycle pulse when sel_a wraps NUM_LANES-1 -> 0.

Function
REQ-018 Each lane l SHALL hold registers reg_a[l], reg_b[l], reg_c[l], each DATA_W bits.
REQ-019 With i_lane_en[l]=1 at an edge: reg_a[l] <= i_a, reg_b[l] <= i_b; with i_lane_en[l]=0 all three lane registers hold.
REQ-020 Indexed write on capture: reg_c[l][i_bit_idx] <= ~(i_bit_val | i_a[i_bit_idx]); other reg_c[l] bits hold.
REQ-021 i_bit_idx >= DATA_W: no reg_c bit written; reg_a/reg_b capture proceeds normally.
REQ-022 Rotate mode: sel_a <= sel_a+1 and sel_b <= sel_b+1, each wrapping NUM_LANES-1 -> 0 (non-power-of-two NUM_LANES included).
REQ-023 Fixed mode: sel_a <= i_fix_sel and sel_b <= i_fix_sel; i_fix_sel >= NUM_LANES leaves both selectors unchanged.
REQ-024 Hold/reserved mode: sel_a, sel_b unchanged.
REQ-025 o_a, o_b, o_c SHALL be combinational muxes of registered state only; no input-to-output combinational path.
REQ-026 Latency: data captured at edge N into lane l appears on o_a after edge N when sel_a = l after that same edge.
REQ-027 o_wrap SHALL be registered: high for exactly the cycle following an edge where rotate mode moved sel_a from NUM_LANES-1 to 0; low otherwise.
REQ-028 Mode change takes effect at the next edge; no cycle is skipped or repeated in the selector sequence.
REQ-029 Capture and selector update on the same edge are independent; o_a after the edge reflects the new selector and the new lane data.

Reset
REQ-030 When i_rst=0 at an edge: all reg_a, reg_b, reg_c = 0; sel_a = 0; sel_b = 1; o_wrap = 0.
REQ-031 Reset SHALL dominate capture, mode and fixed-select inputs on the same edge.
REQ-032 Outputs after reset: o_a = 0, o_b = 0, o_c = 0, o_sel_a = 0, o_sel_b = 1, o_wrap = 0.
REQ-033 Reset asserted mid-rotation SHALL restart the sequence at sel_a=0, sel_b=1 on the first non-reset edge.

Verification (NUM_LANES=4, DATA_W=8)
REQ-034 Reset, then i_mode=00 for 8 cycles -> o_sel_a 1,2,3,0,1,2,3,0; o_sel_b 2,3,0,1,2,3,0,1; o_wrap high only in the cycles after the 3->0 edges.
REQ-035 i_mode=01, i_fix_sel=2, i_lane_en=4'b0100, i_a=8'hA5, i_b=8'h3C for one edge -> o_a=8'hA5, o_b=8'h3C next cycle; other lanes still 0.
REQ-036 Lane 1 enabled, i_bit_idx=5, i_a=8'h00, i_bit_val=0 -> reg_c[1][5]=1, o_c=8'h20; repeat with i_bit_val=1 -> o_c=8'h00.
REQ-037 NUM_LANES=3 build, rotate mode -> o_sel_a 1,2,0,1; wrap pulse after each 2->0 edge; i_fix_sel=3 in fixed mode -> selectors unchanged.
REQ-038 i_rst=0 asserted while i_lane_en=all-ones and i_mode=00 mid-sequence -> next cycle all outputs 0, o_sel_b=1; first post-reset edge gives o_sel_a=1.

Source files
------------

// File: rtl/multi_lane_capture_mux_if.sv
// ---------------------------------------------------------------------------
// multi_lane_capture_mux_if
//   Bus bundle for multi_lane_capture_mux.
//   The master side (the environment) drives the capture/selector controls.
//   The slave side (the mux) drives the lane outputs.
//
//   i_a, i_b      DATA_W     data words broadcast to every lane
//   i_lane_en     NUM_LANES  per-lane capture enable
//   i_bit_idx     IDX_W      bit index for the lane indexed-bit write
//   i_bit_val     1          indexed-bit write operand
//   i_mode        2          00 rotate, 01 fixed, 10/11 hold
//   i_fix_sel     SEL_W      lane number loaded into both selectors in fixed mode
//   o_a, o_b      DATA_W     reg_a of lane sel_a, reg_b of lane sel_b
//   o_c           DATA_W     merged indexed-bit word
//   o_sel_a/b     SEL_W      current selector values
//   o_wrap        1          one-cycle pulse after sel_a wraps to 0
// ---------------------------------------------------------------------------
interface multi_lane_capture_mux_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8
);
  localparam int SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0]    i_a;
  logic [DATA_W-1:0]    i_b;
  logic [NUM_LANES-1:0] i_lane_en;
  logic [IDX_W-1:0]     i_bit_idx;
  logic                 i_bit_val;
  logic [1:0]           i_mode;
  logic [SEL_W-1:0]     i_fix_sel;
  logic [DATA_W-1:0]    o_a;
  logic [DATA_W-1:0]    o_b;
  logic [DATA_W-1:0]    o_c;
  logic [SEL_W-1:0]     o_sel_a;
  logic [SEL_W-1:0]     o_sel_b;
  logic                 o_wrap;

  modport master (
    output i_a, i_b, i_lane_en, i_bit_idx, i_bit_val, i_mode, i_fix_sel,
    input  o_a, o_b, o_c, o_sel_a, o_sel_b, o_wrap
  );

  modport slave (
    input  i_a, i_b, i_lane_en, i_bit_idx, i_bit_val, i_mode, i_fix_sel,
    output o_a, o_b, o_c, o_sel_a, o_sel_b, o_wrap
  );
endinterface

// File: rtl/multi_lane_capture_mux.sv
// ---------------------------------------------------------------------------
// multi_lane_capture_mux
//   NUM_LANES capture lanes, each holding reg_a/reg_b/reg_c (DATA_W bits).
//   Enabled lanes capture i_a/i_b and perform an indexed NOR bit write into
//   reg_c. Two lane selectors (rotate / fixed / hold) pick which lane drives
//   o_a and o_b; o_c gathers bit k from lane (k mod NUM_LANES).
//   Outputs are pure muxes of registered state.
//
//   t_i_clk  clock, rising edge
//   i_rst    synchronous, active-low reset (clears all lane and selector state)
//   bus      multi_lane_capture_mux_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module multi_lane_capture_mux #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8
) (
  input logic                      t_i_clk,
  input logic                      i_rst,
  multi_lane_capture_mux_if.slave  bus
);
  localparam int SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_LANES - 1);
  localparam logic [SEL_W:0]   NUM_LANES_X = (SEL_W + 1)'(NUM_LANES);

  typedef enum logic [1:0] {
    MODE_ROT  = 2'b00,
    MODE_FIX  = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  logic [DATA_W-1:0] reg_a_q [NUM_LANES];
  logic [DATA_W-1:0] reg_b_q [NUM_LANES];
  logic [DATA_W-1:0] reg_c_q [NUM_LANES];
  logic [DATA_W-1:0] reg_a_d [NUM_LANES];
  logic [DATA_W-1:0] reg_b_d [NUM_LANES];
  logic [DATA_W-1:0] reg_c_d [NUM_LANES];
  logic [SEL_W-1:0]  sel_a_q, sel_a_d;
  logic [SEL_W-1:0]  sel_b_q, sel_b_d;
  logic              wrap_q, wrap_d;
  mode_e             mode;

  assign mode = mode_e'(bus.i_mode);

  // Lane capture. An index outside 0..DATA_W-1 matches no bit, so reg_c
  // is left untouched while reg_a/reg_b still capture.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      reg_a_d[l] = reg_a_q[l];
      reg_b_d[l] = reg_b_q[l];
      reg_c_d[l] = reg_c_q[l];
      if (bus.i_lane_en[l]) begin
        reg_a_d[l] = bus.i_a;
        reg_b_d[l] = bus.i_b;
        for (int k = 0; k < DATA_W; k++) begin
          if (bus.i_bit_idx == IDX_W'(k)) begin
            reg_c_d[l][k] = ~(bus.i_bit_val | bus.i_a[k]);
          end
        end
      end
    end
  end

  // Selector update; wrap is flagged on the edge that takes sel_a to 0.
  always_comb begin
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    wrap_d  = 1'b0;
    case (mode)
      MODE_ROT: begin
        sel_a_d = (sel_a_q == LAST_SEL) ? '0 : sel_a_q + 1'b1;
        sel_b_d = (sel_b_q == LAST_SEL) ? '0 : sel_b_q + 1'b1;
        wrap_d  = (sel_a_q == LAST_SEL);
      end
      MODE_FIX: begin
        // Out-of-range lane numbers are ignored rather than aliased.
        if ({1'b0, bus.i_fix_sel} < NUM_LANES_X) begin
          sel_a_d = bus.i_fix_sel;
          sel_b_d = bus.i_fix_sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge t_i_clk) begin
    if (!i_rst) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        reg_a_q[l] <= '0;
        reg_b_q[l] <= '0;
        reg_c_q[l] <= '0;
      end
      sel_a_q <= '0;
      sel_b_q <= SEL_W'(1);
      wrap_q  <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        reg_a_q[l] <= reg_a_d[l];
        reg_b_q[l] <= reg_b_d[l];
        reg_c_q[l] <= reg_c_d[l];
      end
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      wrap_q  <= wrap_d;
    end
  end

  // Output muxes read registered state only.
  always_comb begin
    bus.o_a = '0;
    bus.o_b = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (sel_a_q == SEL_W'(l)) bus.o_a = reg_a_q[l];
      if (sel_b_q == SEL_W'(l)) bus.o_b = reg_b_q[l];
    end
  end

  always_comb begin
    bus.o_c = '0;
    for (int k = 0; k < DATA_W; k++) begin
      bus.o_c[k] = reg_c_q[k % NUM_LANES][k];
    end
  end

  assign bus.o_sel_a = sel_a_q;
  assign bus.o_sel_b = sel_b_q;
  assign bus.o_wrap  = wrap_q;
endmodule

// File: tb/tb_multi_lane_capture_mux.sv
module tb_multi_lane_capture_mux;
  logic clk = 1'b0;
  logic rst4;
  logic rst3;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  multi_lane_capture_mux_if #(.NUM_LANES(4), .DATA_W(8)) if4 ();
  multi_lane_capture_mux_if #(.NUM_LANES(3), .DATA_W(8)) if3 ();

  multi_lane_capture_mux #(.NUM_LANES(4), .DATA_W(8)) dut4 (
    .t_i_clk (clk),
    .i_rst   (rst4),
    .bus     (if4.slave)
  );

  multi_lane_capture_mux #(.NUM_LANES(3), .DATA_W(8)) dut3 (
    .t_i_clk (clk),
    .i_rst   (rst3),
    .bus     (if3.slave)
  );

  int exp4_sa [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int exp4_sb [8] = '{2, 3, 0, 1, 2, 3, 0, 1};
  int exp4_w  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int exp3_sa [4] = '{1, 2, 0, 1};
  int exp3_sb [4] = '{2, 0, 1, 2};
  int exp3_w  [4] = '{0, 0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input int sa, input int sb, input logic w);
    chk({tag, " o_a"},     32'(if4.o_a),     32'(a));
    chk({tag, " o_b"},     32'(if4.o_b),     32'(b));
    chk({tag, " o_c"},     32'(if4.o_c),     32'(c));
    chk({tag, " o_sel_a"}, 32'(if4.o_sel_a), 32'(sa));
    chk({tag, " o_sel_b"}, 32'(if4.o_sel_b), 32'(sb));
    chk({tag, " o_wrap"},  32'(if4.o_wrap),  32'(w));
  endtask

  initial begin
    // Reset applied while every capture/select input is active.
    rst4 = 1'b0;
    rst3 = 1'b0;
    if4.i_a = 8'hFF; if4.i_b = 8'hFF; if4.i_lane_en = 4'hF;
    if4.i_bit_idx = 3'd0; if4.i_bit_val = 1'b0;
    if4.i_mode = 2'b01; if4.i_fix_sel = 2'd3;
    if3.i_a = 8'h00; if3.i_b = 8'h00; if3.i_lane_en = 3'b000;
    if3.i_bit_idx = 3'd0; if3.i_bit_val = 1'b0;
    if3.i_mode = 2'b00; if3.i_fix_sel = 2'd0;
    #2;
    tick();
    chk4_all("reset", 8'h00, 8'h00, 8'h00, 0, 1, 1'b0);

    // Rotate for 8 cycles from reset.
    rst4 = 1'b1;
    if4.i_lane_en = 4'h0; if4.i_mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rot4 sel_a %0d", i), 32'(if4.o_sel_a), 32'(exp4_sa[i]));
      chk($sformatf("rot4 sel_b %0d", i), 32'(if4.o_sel_b), 32'(exp4_sb[i]));
      chk($sformatf("rot4 wrap %0d", i),  32'(if4.o_wrap),  32'(exp4_w[i]));
    end

    // Fixed select to lane 2 while capturing into lane 2 only.
    if4.i_mode = 2'b01; if4.i_fix_sel = 2'd2; if4.i_lane_en = 4'b0100;
    if4.i_a = 8'hA5; if4.i_b = 8'h3C; if4.i_bit_idx = 3'd0; if4.i_bit_val = 1'b0;
    tick();
    chk4_all("fix2", 8'hA5, 8'h3C, 8'h00, 2, 2, 1'b0);

    // Other lanes untouched.
    if4.i_lane_en = 4'b0000; if4.i_fix_sel = 2'd0;
    tick();
    chk("fix0 o_a", 32'(if4.o_a), 32'h00);
    chk("fix0 o_b", 32'(if4.o_b), 32'h00);
    if4.i_fix_sel = 2'd3;
    tick();
    chk("fix3 o_a", 32'(if4.o_a), 32'h00);
    chk("fix3 sel_b", 32'(if4.o_sel_b), 32'd3);
    if4.i_fix_sel = 2'd0;
    tick();

    // Indexed-bit write into lane 1 bit 5 in hold mode.
    if4.i_mode = 2'b10; if4.i_lane_en = 4'b0010;
    if4.i_a = 8'h00; if4.i_b = 8'h00; if4.i_bit_idx = 3'd5; if4.i_bit_val = 1'b0;
    tick();
    chk("bitw set o_c", 32'(if4.o_c), 32'h20);
    chk("hold sel_a", 32'(if4.o_sel_a), 32'd0);
    chk("hold sel_b", 32'(if4.o_sel_b), 32'd0);
    if4.i_bit_val = 1'b1;
    tick();
    chk("bitw clr o_c", 32'(if4.o_c), 32'h00);

    // Bit 4 is taken from lane 0; also check the NOR with i_a.
    if4.i_mode = 2'b11; if4.i_lane_en = 4'b0001; if4.i_bit_idx = 3'd4; if4.i_bit_val = 1'b0;
    tick();
    chk("bitw lane0 o_c", 32'(if4.o_c), 32'h10);
    chk("rsvd sel_a", 32'(if4.o_sel_a), 32'd0);
    if4.i_lane_en = 4'b0010; if4.i_bit_idx = 3'd5; if4.i_a = 8'h20;
    tick();
    chk("bitw nor a o_c", 32'(if4.o_c), 32'h10);

    // Capture and rotate on the same edge: o_a shows new lane and new data.
    if4.i_mode = 2'b00; if4.i_lane_en = 4'b0010;
    if4.i_a = 8'h5A; if4.i_b = 8'hC3; if4.i_bit_idx = 3'd0; if4.i_bit_val = 1'b0;
    tick();
    chk4_all("cap+rot", 8'h5A, 8'hC3, 8'h10, 1, 1, 1'b0);

    // Reset mid-rotation with all lanes enabled.
    if4.i_lane_en = 4'hF; if4.i_a = 8'h77; if4.i_b = 8'h66;
    tick();
    rst4 = 1'b0;
    tick();
    chk4_all("midrst", 8'h00, 8'h00, 8'h00, 0, 1, 1'b0);
    rst4 = 1'b1;
    tick();
    chk4_all("postrst", 8'h77, 8'h66, 8'h00, 1, 2, 1'b0);

    // Three-lane build: non-power-of-two wrap and out-of-range fixed select.
    rst3 = 1'b1;
    if3.i_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rot3 sel_a %0d", i), 32'(if3.o_sel_a), 32'(exp3_sa[i]));
      chk($sformatf("rot3 sel_b %0d", i), 32'(if3.o_sel_b), 32'(exp3_sb[i]));
      chk($sformatf("rot3 wrap %0d", i),  32'(if3.o_wrap),  32'(exp3_w[i]));
    end
    if3.i_mode = 2'b01; if3.i_fix_sel = 2'd3;
    tick();
    chk("fix3oor sel_a", 32'(if3.o_sel_a), 32'd1);
    chk("fix3oor sel_b", 32'(if3.o_sel_b), 32'd2);
    chk("fix3oor wrap",  32'(if3.o_wrap),  32'd0);
    if3.i_fix_sel = 2'd2;
    tick();
    chk("fix3 sel_a", 32'(if3.o_sel_a), 32'd2);
    chk("fix3 sel_b", 32'(if3.o_sel_b), 32'd2);
    if3.i_mode = 2'b00;
    tick();
    chk("rot3 wrap2 sel_a", 32'(if3.o_sel_a), 32'd0);
    chk("rot3 wrap2 sel_b", 32'(if3.o_sel_b), 32'd0);
    chk("rot3 wrap2 wrap",  32'(if3.o_wrap),  32'd1);
    if3.i_mode = 2'b10;
    tick();
    chk("hold3 wrap",  32'(if3.o_wrap),  32'd0);
    chk("hold3 sel_a", 32'(if3.o_sel_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
